// File: rtl/aesl_axis_stall_detector_if.sv
// rtl/aesl_axis_stall_detector_if.sv - stream taps and block status bundle for the stall detector
// The monitor side (slave) only observes the stream handshakes and reports block status.
interface aesl_axis_stall_detector_if #(
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ch_tvalid;
    logic [NUM_CH-1:0] ch_tready;
    logic [NUM_CH-1:0] ch_rd_wait;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic [NUM_CH-1:0] block_is_full;
    logic              first_block_valid;
    logic [CH_W-1:0]   first_block_ch;

    modport master (
        output ch_tvalid,
        output ch_tready,
        output ch_rd_wait,
        input  axis_block_sigs,
        input  block_is_full,
        input  first_block_valid,
        input  first_block_ch
    );

    modport slave (
        input  ch_tvalid,
        input  ch_tready,
        input  ch_rd_wait,
        output axis_block_sigs,
        output block_is_full,
        output first_block_valid,
        output first_block_ch
    );
endinterface

// File: rtl/aesl_axis_stall_detector.sv
// rtl/aesl_axis_stall_detector.sv - per-channel AXI-Stream stall/block detector with first-block capture
// Each channel counts consecutive stall cycles and declares a block after THRESH of them.
module aesl_axis_stall_detector #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int THRESH = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    aesl_axis_stall_detector_if.slave axis
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_BLOCK = 2'd2
    } ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] full_stall;
    logic [NUM_CH-1:0] empty_stall;
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] progress;
    logic [NUM_CH-1:0] enter_block;
    logic [NUM_CH-1:0] block_q;
    logic [NUM_CH-1:0] block_d;
    logic [NUM_CH-1:0] is_full_q;
    logic [NUM_CH-1:0] is_full_d;
    logic              first_valid_q;
    logic              first_valid_d;
    logic [CH_W-1:0]   first_ch_q;
    logic [CH_W-1:0]   first_ch_d;

    // Full: producer offers data nobody takes. Empty: consumer waits on no data.
    assign full_stall  = axis.ch_tvalid & ~axis.ch_tready;
    assign empty_stall = axis.ch_rd_wait & ~axis.ch_tvalid;
    assign stall       = full_stall | empty_stall;
    assign progress    = axis.ch_tvalid & axis.ch_tready;

    always_comb begin
        enter_block = '0;
        block_d     = '0;
        is_full_d   = is_full_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clear || !enable) begin
                state_d[i]   = ST_RUN;
                cnt_d[i]     = '0;
                is_full_d[i] = 1'b0;
            end else begin
                case (state_q[i])
                    ST_RUN: begin
                        cnt_d[i]     = '0;
                        is_full_d[i] = 1'b0;
                        if (stall[i]) begin
                            state_d[i] = ST_STALL;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    ST_STALL: begin
                        if (progress[i] || !stall[i]) begin
                            state_d[i] = ST_RUN;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            // Stall type may have flipped en route; the entry cycle decides it.
                            state_d[i]     = ST_BLOCK;
                            cnt_d[i]       = CNT_THR;
                            is_full_d[i]   = full_stall[i];
                            enter_block[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    ST_BLOCK: begin
                        if (progress[i] || !stall[i]) begin
                            state_d[i]   = ST_RUN;
                            cnt_d[i]     = '0;
                            is_full_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = CNT_THR;
                        end
                    end
                    default: begin
                        state_d[i]   = ST_RUN;
                        cnt_d[i]     = '0;
                        is_full_d[i] = 1'b0;
                    end
                endcase
            end
            block_d[i] = (state_d[i] == ST_BLOCK);
        end
    end

    // Sticky capture of the first blocking channel; descending scan leaves the lowest index.
    always_comb begin
        first_valid_d = first_valid_q;
        first_ch_d    = first_ch_q;
        if (clear) begin
            first_valid_d = 1'b0;
            first_ch_d    = '0;
        end else if (!first_valid_q && (|enter_block)) begin
            first_valid_d = 1'b1;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (enter_block[i]) begin
                    first_ch_d = CH_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end
            block_q       <= '0;
            is_full_q     <= '0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            block_q       <= block_d;
            is_full_q     <= is_full_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
        end
    end

    assign axis.axis_block_sigs   = block_q;
    assign axis.block_is_full     = is_full_q;
    assign axis.first_block_valid = first_valid_q;
    assign axis.first_block_ch    = first_ch_q;

endmodule

// File: tb/tb_aesl_axis_stall_detector.sv
// tb/tb_aesl_axis_stall_detector.sv - scoreboard bench for aesl_axis_stall_detector (THRESH=4, NUM_CH=2)
// Stimulus pushes hand-computed expectations; a monitor pops and compares at each falling edge.
module tb_aesl_axis_stall_detector;
    localparam int I = 0;  // idle
    localparam int F = 1;  // full stall
    localparam int E = 2;  // empty stall
    localparam int P = 3;  // progress

    typedef struct {
        string      name;
        logic [1:0] blk;
        logic [1:0] full;
        logic       fbv;
        logic       fbch;
    } exp_t;

    logic clock;
    logic reset;
    logic enable;
    logic clear;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    event chk_now;

    aesl_axis_stall_detector_if #(.NUM_CH(2)) bus ();

    aesl_axis_stall_detector #(
        .NUM_CH (2),
        .CNT_W  (16),
        .THRESH (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .axis   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic set_ch(input int idx, input int mode);
        bus.ch_tvalid[idx]  = (mode == F) || (mode == P);
        bus.ch_tready[idx]  = (mode == P);
        bus.ch_rd_wait[idx] = (mode == E);
    endtask

    task automatic push_exp(input string n, input logic [1:0] b, input logic [1:0] f,
                            input logic v, input logic c);
        exp_t e;
        e.name = n;
        e.blk  = b;
        e.full = f;
        e.fbv  = v;
        e.fbch = c;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input int m0, input int m1, input logic clr, input string n,
                       input logic [1:0] b, input logic [1:0] f, input logic v, input logic c);
        @(negedge clock);
        set_ch(0, m0);
        set_ch(1, m1);
        clear = clr;
        @(posedge clock);
        #1;
        push_exp(n, b, f, v, c);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock or chk_now);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.axis_block_sigs !== e.blk || bus.block_is_full !== e.full ||
                    bus.first_block_valid !== e.fbv || bus.first_block_ch !== e.fbch) begin
                    errors++;
                    $display("FAIL %s: got blk=%b full=%b fbv=%b fbch=%b, want blk=%b full=%b fbv=%b fbch=%b",
                             e.name, bus.axis_block_sigs, bus.block_is_full, bus.first_block_valid,
                             bus.first_block_ch, e.blk, e.full, e.fbv, e.fbch);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        set_ch(0, I);
        set_ch(1, I);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        cyc(I, I, 0, "reset_state", 2'b00, 2'b00, 0, 0);

        // ch0 full stall reaches THRESH on the 4th edge
        for (int k = 0; k < 3; k++) cyc(F, I, 0, "a_pre", 2'b00, 2'b00, 0, 0);
        cyc(F, I, 0, "a_block",   2'b01, 2'b01, 1, 0);
        cyc(F, I, 0, "a_hold",    2'b01, 2'b01, 1, 0);
        cyc(I, I, 0, "a_release", 2'b00, 2'b00, 1, 0);
        cyc(I, I, 1, "a_clear",   2'b00, 2'b00, 0, 0);

        // ch1 empty stall broken by one progress cycle never blocks
        for (int k = 0; k < 3; k++) cyc(I, E, 0, "b_stall1", 2'b00, 2'b00, 0, 0);
        cyc(I, P, 0, "b_progress", 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) cyc(I, E, 0, "b_stall2", 2'b00, 2'b00, 0, 0);
        cyc(I, I, 0, "b_idle", 2'b00, 2'b00, 0, 0);

        // both channels block on the same edge: lowest index captured
        for (int k = 0; k < 3; k++) cyc(F, E, 0, "c_pre", 2'b00, 2'b00, 0, 0);
        cyc(F, E, 0, "c_block", 2'b11, 2'b01, 1, 0);
        cyc(I, I, 1, "c_clear", 2'b00, 2'b00, 0, 0);

        // ch1 first, then ch0, then ch1 releases; capture stays on ch1
        for (int k = 0; k < 3; k++) cyc(I, F, 0, "d_pre1", 2'b00, 2'b00, 0, 0);
        cyc(I, F, 0, "d_blk1", 2'b10, 2'b10, 1, 1);
        for (int k = 0; k < 3; k++) cyc(F, F, 0, "d_pre0", 2'b10, 2'b10, 1, 1);
        cyc(F, F, 0, "d_blk01", 2'b11, 2'b11, 1, 1);
        cyc(F, I, 0, "d_rel1",  2'b01, 2'b01, 1, 1);
        cyc(I, I, 0, "d_rel0",  2'b00, 2'b00, 1, 1);
        cyc(I, I, 1, "d_clear", 2'b00, 2'b00, 0, 0);

        // clear on the would-be block edge wins, then re-block after 4 more edges
        for (int k = 0; k < 3; k++) cyc(F, I, 0, "e_pre", 2'b00, 2'b00, 0, 0);
        cyc(F, I, 1, "e_clear_at_thresh", 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) cyc(F, I, 0, "e_recount", 2'b00, 2'b00, 0, 0);
        cyc(F, I, 0, "e_reblock", 2'b01, 2'b01, 1, 0);

        // enable low drops the block but keeps the sticky capture
        enable = 1'b0;
        cyc(F, I, 0, "f_disable", 2'b00, 2'b00, 1, 0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) cyc(F, I, 0, "f_recount", 2'b00, 2'b00, 1, 0);
        cyc(F, I, 0, "f_reblock", 2'b01, 2'b01, 1, 0);

        // full-to-empty change keeps counting; entry cycle is empty so type is 0
        cyc(I, I, 1, "g_clear", 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 2; k++) cyc(F, I, 0, "g_full", 2'b00, 2'b00, 0, 0);
        cyc(E, I, 0, "g_empty", 2'b00, 2'b00, 0, 0);
        cyc(E, I, 0, "g_block_empty", 2'b01, 2'b00, 1, 0);

        // asynchronous reset while blocked clears outputs before the next edge
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        push_exp("h_async_reset", 2'b00, 2'b00, 0, 0);
        ->chk_now;
        @(negedge clock);
        set_ch(0, I);
        set_ch(1, I);
        reset = 1'b1;
        cyc(I, I, 0, "h_after_reset", 2'b00, 2'b00, 0, 0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aesl_axis_stall_detector.md
AESL_AXIS_STALL_DETECTOR -- requirements
Module: AESL_axis_stall_detector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of AXI-Stream channels watched.
REQ-002 The block SHALL have parameter CNT_W, default 16: stall counter width in bits.
REQ-003 The block SHALL have parameter THRESH, default 1000: consecutive stall cycles that declare a block; legal range 2 to 2^CNT_W-1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: monitoring enable.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear of all channel state and sticky capture.
REQ-008 The block SHALL have port ch_tvalid, input, NUM_CH bits: per-channel stream TVALID.
REQ-009 The block SHALL have port ch_tready, input, NUM_CH bits: per-channel stream TREADY.
REQ-010 The block SHALL have port ch_rd_wait, input, NUM_CH bits: per-channel consumer read attempt pending.
REQ-011 The block SHALL have port axis_block_sigs, output, NUM_CH bits: per-channel blocked flag, which feeds the deadlock monitor.
REQ-012 The block SHALL have port block_is_full, output, NUM_CH bits: per-channel block type, 1 = full (producer stalled) and 0 = empty (consumer starved).
REQ-013 The block SHALL have port first_block_valid, output, 1 bit: sticky flag, set when the first block is declared.
REQ-014 The block SHALL have port first_block_ch, output, $clog2(NUM_CH) bits (minimum 1): index of the first channel to block.

Function
REQ-015 Per channel, full stall SHALL be tvalid & ~tready, empty stall SHALL be rd_wait & ~tvalid, and stall SHALL be their OR; progress SHALL be tvalid & tready.
REQ-016 Each channel SHALL run an independent FSM with states RUN, STALL and BLOCK, plus a CNT_W-bit counter cnt.
REQ-017 In RUN, cnt SHALL be 0; stall & enable SHALL move the FSM to STALL with cnt=1.
REQ-018 In STALL, a cycle with progress, ~stall or ~enable SHALL return the FSM to RUN with cnt=0; otherwise cnt SHALL increment by 1.
REQ-019 In STALL with cnt==THRESH-1 and stall still high, the FSM SHALL move to BLOCK; cnt SHALL then hold at THRESH and never wrap.
REQ-020 Latency: if stall is high on THRESH consecutive sampled edges starting at edge k, axis_block_sigs[i] SHALL be 1 from edge k+THRESH-1, registered, visible in the following cycle.
REQ-021 In BLOCK, axis_block_sigs[i] SHALL be 1; the first edge with ~stall, progress or ~enable SHALL return the FSM to RUN and drive axis_block_sigs[i]=0 after that edge.
REQ-022 A stall-type change (full to empty or the reverse) without an intervening non-stall cycle SHALL keep counting.
REQ-023 block_is_full[i] SHALL register the full-stall term on the edge that enters BLOCK, SHALL hold while in BLOCK, and SHALL be 0 outside BLOCK.
REQ-024 axis_block_sigs SHALL be driven directly from the FSM state register, with no combinational path from inputs.
REQ-025 On the first edge where any channel enters BLOCK while first_block_valid=0, the block SHALL set first_block_valid=1 and load first_block_ch.
REQ-026 If several channels enter BLOCK on the same edge, the lowest index SHALL be captured.
REQ-027 first_block_valid and first_block_ch SHALL remain unchanged by later blocks or by unblocking until clear or reset.
REQ-028 clear=1 SHALL, at the edge, force all FSMs to RUN, set cnt=0, axis_block_sigs=0, block_is_full=0, first_block_valid=0 and first_block_ch=0.
REQ-029 clear SHALL have priority over stall and enable, including when clear and a block entry occur on the same edge.
REQ-030 enable=0 SHALL force every FSM to RUN with cnt=0 and SHALL NOT alter the sticky capture.

Reset
REQ-031 reset=0 SHALL asynchronously force all FSMs to RUN, cnt=0, axis_block_sigs=0, block_is_full=0, first_block_valid=0 and first_block_ch=0.
REQ-032 After reset deasserts, the first evaluated edge SHALL be the edge following deassertion.
REQ-033 Reset asserted mid-STALL or mid-BLOCK SHALL clear the outputs immediately, without waiting for a clock edge.

Verification (THRESH=4, NUM_CH=2, enable=1)
REQ-034 Bench SHALL drive ch0 tvalid=1, tready=0 for 4 cycles -> axis_block_sigs=2'b01 after the 4th edge, block_is_full[0]=1, first_block_valid=1, first_block_ch=0.
REQ-035 Bench SHALL drive ch1 rd_wait=1, tvalid=0 for 3 cycles, then 1 cycle with tvalid=1, tready=1, then 3 stall cycles -> axis_block_sigs stays 2'b00.
REQ-036 Bench SHALL stall both channels from the same edge for 4 cycles -> axis_block_sigs=2'b11, first_block_ch=0.
REQ-037 Bench SHALL block ch1 first, then block ch0, then release ch1 -> axis_block_sigs goes 10, 11, 01, and first_block_ch stays 1 throughout.
REQ-038 Bench SHALL pulse clear on the edge ch0 would reach THRESH -> axis_block_sigs=0, first_block_valid=0; holding the stall re-blocks after 4 more edges.
REQ-039 Bench SHALL assert reset=0 asynchronously while in BLOCK -> all outputs 0 before the next clock edge.
